// File: rtl/freq_meas_pkg.sv
// rtl/freq_meas_pkg.sv - shared widths, saturation value and FSM states for freq_calc
package freq_meas_pkg;
  localparam int PERIOD_W = 32;
  localparam int CYC_W    = 16;
  localparam int NUM_W    = 48;
  localparam int FREQ_W   = 32;

  localparam logic [FREQ_W-1:0] SAT_VAL = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;
endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - bit-serial restoring divider, one quotient bit per cycle, MSB first
module seq_divider
  import freq_meas_pkg::*;
#(
  parameter int N_W = NUM_W,
  parameter int D_W = PERIOD_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N_W-1:0] numerator,
  input  logic [D_W-1:0] denominator,
  output logic           done,
  output logic [N_W-1:0] quotient
);
  localparam int CNT_W = $clog2(N_W);

  logic [N_W-1:0]   num_q;
  logic [N_W-1:0]   quo_q;
  logic [D_W:0]     rem_q;
  logic [D_W-1:0]   den_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy;
  logic [D_W:0]     rem_sh;
  logic [D_W:0]     rem_nxt;
  logic             take;

  // quotient is the value after this cycle's iteration, so it is final while done is high
  always_comb begin
    rem_sh   = {rem_q[D_W-1:0], num_q[N_W-1]};
    take     = (rem_sh >= {1'b0, den_q});
    rem_nxt  = take ? (rem_sh - {1'b0, den_q}) : rem_sh;
    quotient = {quo_q[N_W-2:0], take};
    done     = busy && (cnt_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      den_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      num_q <= numerator;
      den_q <= denominator;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= CNT_W'(N_W - 1);
      busy  <= 1'b1;
    end else if (busy) begin
      num_q <= {num_q[N_W-2:0], 1'b0};
      rem_q <= rem_nxt;
      quo_q <= quotient;
      cnt_q <= cnt_q - CNT_W'(1);
      if (cnt_q == '0) begin
        busy <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/freq_calc.sv
// rtl/freq_calc.sv - converts a gated period count into a saturated frequency in Hz
module freq_calc
  import freq_meas_pkg::*;
#(
  parameter logic [31:0] PLL_FREQ = 32'd200_000_000
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                meas_valid,
  output logic                meas_ready,
  input  logic [PERIOD_W-1:0] meas_period,
  input  logic [CYC_W-1:0]    meas_cycles,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [FREQ_W-1:0]   freq_hz,
  output logic                freq_sat,
  output logic                freq_err
);
  state_t              state;
  state_t              state_nxt;
  logic [PERIOD_W-1:0] period_q;
  logic [CYC_W-1:0]    cycles_q;
  logic [NUM_W-1:0]    numerator;
  logic [NUM_W-1:0]    quotient;
  logic                div_start;
  logic                div_done;
  logic                quo_ovf;

  assign numerator  = NUM_W'(cycles_q) * NUM_W'(PLL_FREQ);
  assign quo_ovf    = |quotient[NUM_W-1:FREQ_W];
  assign meas_ready = (state == IDLE);

  always_comb begin
    state_nxt = state;
    div_start = 1'b0;
    case (state)
      IDLE: if (meas_valid) state_nxt = MUL;
      MUL: begin
        if (period_q == '0) begin
          state_nxt = DONE;
        end else begin
          div_start = 1'b1;
          state_nxt = DIV;
        end
      end
      DIV:  if (div_done) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      period_q  <= '0;
      cycles_q  <= '0;
      out_valid <= 1'b0;
      freq_hz   <= '0;
      freq_sat  <= 1'b0;
      freq_err  <= 1'b0;
    end else begin
      out_valid <= (state_nxt == DONE);
      if (state == IDLE && meas_valid) begin
        period_q <= meas_period;
        cycles_q <= meas_cycles;
      end
      if (state == MUL && period_q == '0) begin
        freq_hz  <= SAT_VAL;
        freq_sat <= 1'b0;
        freq_err <= 1'b1;
      end
      if (state == DIV && div_done) begin
        freq_hz  <= quo_ovf ? SAT_VAL : quotient[FREQ_W-1:0];
        freq_sat <= quo_ovf;
        freq_err <= 1'b0;
      end
    end
  end

  seq_divider #(
    .N_W(NUM_W),
    .D_W(PERIOD_W)
  ) u_div (
    .clk        (sys_clk),
    .rst        (sys_rst),
    .start      (div_start),
    .numerator  (numerator),
    .denominator(period_q),
    .done       (div_done),
    .quotient   (quotient)
  );
endmodule

// File: tb/tb_freq_calc.sv
// tb/tb_freq_calc.sv - self-checking bench for freq_calc
module tb_freq_calc;
  localparam longint unsigned PLL = 64'd200_000_000;

  logic        sys_clk;
  logic        sys_rst;
  logic        meas_valid;
  logic        meas_ready;
  logic [31:0] meas_period;
  logic [15:0] meas_cycles;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] freq_hz;
  logic        freq_sat;
  logic        freq_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] period;
    logic [15:0] cycles;
    logic [31:0] hz;
    bit          sat;
    bit          err;
    int          lat;
  } vec_t;

  freq_calc dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .meas_period(meas_period),
    .meas_cycles(meas_cycles),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .freq_hz    (freq_hz),
    .freq_sat   (freq_sat),
    .freq_err   (freq_err)
  );

  initial begin
    sys_clk = 1'b0;
    forever #10 sys_clk = ~sys_clk;
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // reference: frequency from plain integer arithmetic
  task automatic model(input logic [31:0] p, input logic [15:0] n,
                       output logic [31:0] hz, output bit sat, output bit err);
    longint unsigned q;
    err = (p == 0);
    sat = 1'b0;
    hz  = 32'hFFFF_FFFF;
    if (!err) begin
      q   = (64'(n) * PLL) / 64'(p);
      sat = (q > 64'hFFFF_FFFF);
      hz  = sat ? 32'hFFFF_FFFF : q[31:0];
    end
  endtask

  task automatic run_meas(input logic [31:0] p, input logic [15:0] n, input logic [31:0] ehz,
                          input bit esat, input bit eerr, input int elat, input int rdy_wait,
                          input string tag);
    int lat;
    meas_period = p;
    meas_cycles = n;
    meas_valid  = 1'b1;
    tick();
    meas_valid  = 1'b0;
    meas_period = $urandom;
    meas_cycles = 16'($urandom);
    chk({tag, "/ready_low"}, 64'(meas_ready), 64'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      tick();
      lat++;
    end
    chk({tag, "/latency"}, 64'(lat), 64'(elat));
    chk({tag, "/hz"}, 64'(freq_hz), 64'(ehz));
    chk({tag, "/sat"}, 64'(freq_sat), 64'(esat));
    chk({tag, "/err"}, 64'(freq_err), 64'(eerr));
    repeat (rdy_wait) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, "/valid_clr"}, 64'(out_valid), 64'd0);
    chk({tag, "/ready_back"}, 64'(meas_ready), 64'd1);
    chk({tag, "/hz_kept"}, 64'(freq_hz), 64'(ehz));
  endtask

  initial begin
    vec_t        vecs[6];
    logic [31:0] p;
    logic [15:0] n;
    logic [31:0] ehz;
    bit          esat;
    bit          eerr;
    int          bad;

    vecs[0] = '{32'd2_000_000,   16'd100,   32'd10_000,      1'b0, 1'b0, 49};
    vecs[1] = '{32'd7,           16'd3,     32'd85_714_285,  1'b0, 1'b0, 49};
    vecs[2] = '{32'd0,           16'd5,     32'hFFFF_FFFF,   1'b0, 1'b1, 1};
    vecs[3] = '{32'd1,           16'd65535, 32'hFFFF_FFFF,   1'b1, 1'b0, 49};
    vecs[4] = '{32'd1000,        16'd0,     32'd0,           1'b0, 1'b0, 49};
    vecs[5] = '{32'd200_000_000, 16'd1,     32'd1,           1'b0, 1'b0, 49};

    sys_rst     = 1'b1;
    meas_valid  = 1'b0;
    out_ready   = 1'b0;
    meas_period = '0;
    meas_cycles = '0;
    tick();
    tick();
    sys_rst = 1'b0;
    chk("rst/ready", 64'(meas_ready), 64'd1);
    chk("rst/valid", 64'(out_valid), 64'd0);
    chk("rst/hz", 64'(freq_hz), 64'd0);
    chk("rst/sat", 64'(freq_sat), 64'd0);
    chk("rst/err", 64'(freq_err), 64'd0);

    for (int i = 0; i < 6; i++) begin
      run_meas(vecs[i].period, vecs[i].cycles, vecs[i].hz, vecs[i].sat, vecs[i].err,
               vecs[i].lat, i % 3, $sformatf("vec%0d", i));
      tick();
    end

    // result held for 200 cycles while upstream keeps offering work
    meas_period = 32'd3;
    meas_cycles = 16'd7;
    meas_valid  = 1'b1;
    tick();
    meas_valid = 1'b0;
    bad = 0;
    while (!out_valid && bad < 200) begin
      tick();
      bad++;
    end
    chk("hold/latency", 64'(bad), 64'd49);
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      meas_valid  = (i == 50 || i == 120 || i == 199);
      meas_period = 32'd5;
      meas_cycles = 16'd1;
      tick();
      if (freq_hz !== 32'd466_666_666 || meas_ready !== 1'b0 || out_valid !== 1'b1) bad++;
    end
    chk("hold/unstable_cycles", 64'(bad), 64'd0);
    out_ready = 1'b1;
    tick();
    out_ready  = 1'b0;
    meas_valid = 1'b0;
    chk("hold/valid_clr", 64'(out_valid), 64'd0);
    chk("hold/ready_back", 64'(meas_ready), 64'd1);
    tick();
    chk("hold/not_accepted", 64'(meas_ready), 64'd1);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (out_valid !== 1'b0 || meas_ready !== 1'b1) bad++;
    end
    chk("hold/idle_after", 64'(bad), 64'd0);
    chk("hold/hz_kept", 64'(freq_hz), 64'd466_666_666);

    // reset in the middle of the division
    meas_period = 32'd12345;
    meas_cycles = 16'd9;
    meas_valid  = 1'b1;
    tick();
    meas_valid = 1'b0;
    repeat (21) tick();
    chk("midrst/busy", 64'(meas_ready), 64'd0);
    sys_rst = 1'b1;
    tick();
    sys_rst = 1'b0;
    chk("midrst/ready", 64'(meas_ready), 64'd1);
    chk("midrst/valid", 64'(out_valid), 64'd0);
    chk("midrst/hz", 64'(freq_hz), 64'd0);
    chk("midrst/sat", 64'(freq_sat), 64'd0);
    chk("midrst/err", 64'(freq_err), 64'd0);
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    chk("midrst/discarded", 64'(bad), 64'd0);
    run_meas(32'd200_000_000, 16'd1, 32'd1, 1'b0, 1'b0, 49, 0, "post_rst");

    for (int i = 0; i < 30; i++) begin
      n = 16'($urandom_range(0, 65535));
      case ($urandom_range(0, 3))
        0:       p = 32'($urandom_range(1, 15));
        1:       p = $urandom;
        2:       p = 32'($urandom_range(1000, 10_000_000));
        default: p = 32'($urandom_range(0, 3));
      endcase
      model(p, n, ehz, esat, eerr);
      run_meas(p, n, ehz, esat, eerr, eerr ? 1 : 49, $urandom_range(0, 3),
               $sformatf("rnd%0d_p%0d_n%0d", i, p, n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
